ysyx_22040088_mem_arb: RTL and testbench
========================================

// Module: ysyx_22040088_mem_arb
// PURPOSE
//  Two-requester arbiter/sequencer sharing one data-memory port between IFU (fetch) and LSU (load/store).
//  Sits between the core's fetch/execute stages and the DPI-backed memory model once fetch moves off its private port.
//  One outstanding transaction at a time; round-robin grant; valid/ready request, single-beat response per requester.
// PARAMETERS
//  ADDR_W  64  address width, all ports
//  DATA_W  64  data width, all ports
//  MASK_W  8   byte-write-mask width (DATA_W/8)
// PORTS
//  clk             in   1       clock; all state changes on posedge
//  rst             in   1       reset, synchronous, active-high
//  ifu_req_valid   in   1       fetch request (read only)
//  ifu_req_ready   out  1       fetch request accepted this cycle
//  ifu_addr        in   ADDR_W  fetch address
//  ifu_resp_valid  out  1       fetch data valid (one-cycle pulse)
//  ifu_rdata       out  DATA_W  fetch data
//  lsu_req_valid   in   1       load/store request
//  lsu_req_ready   out  1       load/store request accepted this cycle
//  lsu_addr        in   ADDR_W  load/store address
//  lsu_wen         in   1       1 = store, 0 = load
//  lsu_wdata       in   DATA_W  store data
//  lsu_wmask       in   MASK_W  store byte mask
//  lsu_resp_valid  out  1       load data / store ack valid (one-cycle pulse)
//  lsu_rdata       out  DATA_W  load data (don't-care for stores)
//  mem_req_valid   out  1       request to memory
//  mem_req_ready   in   1       memory accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields
//  mem_resp_valid  in   1       memory response
//  mem_rdata       in   DATA_W  memory read data
//  busy            out  1       state != IDLE
//  stray_resp      out  1       sticky: mem_resp_valid seen outside RESP; cleared only by rst
// BEHAVIOUR
//  States: IDLE -> REQ -> RESP -> IDLE. rst: state=IDLE, owner=IFU, last_grant=LSU, stray_resp=0,
//   all req_ready/resp_valid/mem_req_valid=0, latched mem_* fields=0.
//  IDLE: grant computed combinationally; *_req_ready=1 only for the winner, only in IDLE.
//   Only one valid -> it wins. Both valid -> requester != last_grant wins (first tie after rst -> IFU).
//   On grant: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0), set owner, last_grant=owner, go REQ.
//  REQ: mem_req_valid=1, fields stable; mem_req_valid && mem_req_ready -> RESP. Held indefinitely otherwise.
//  RESP: mem_resp_valid -> owner's resp_valid=1 same cycle, rdata=mem_rdata (combinational pass), -> IDLE.
//   Non-owner resp_valid always 0. rdata outputs = mem_rdata at all times (qualify by resp_valid).
//  Min latency: grant cycle T, mem_req_valid at T+1, earliest resp_valid at T+2; next grant at T+3.
//  mem_resp_valid in IDLE or REQ: ignored (no resp forwarded, no state change), stray_resp<=1.
//  Requester deasserting valid after grant: no effect; transaction completes and response still pulses.
//  rst mid-transaction: abandoned, IDLE next cycle, no response pulses; late mem_resp sets stray_resp.
//  Requester fields sampled only on grant; changes during REQ/RESP do not reach mem_*.
// STRUCTURE
//  Package ysyx_22040088_mem_pkg: state enum {IDLE,REQ,RESP}, owner encoding {OWN_IFU=0,OWN_LSU=1}.
//  Sub-module ysyx_22040088_rr_arb2: combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]).
//  Top holds FSM, owner/last_grant regs, request latch, response steering, stray flag.
// TESTING
//  1 IFU only: addr=0x80000000, mem_req_ready=1, mem_resp at T+2 with rdata=0x00100073 -> ifu_resp_valid pulse T+2, rdata match, lsu_resp_valid=0.
//  2 Both valid every cycle from rst -> grants IFU,LSU,IFU,LSU alternate; each mem_addr matches granted requester.
//  3 LSU store addr=0x80001000 wdata=0xDEADBEEF wmask=0x0F, mem_req_ready low 5 cycles -> mem_req_valid held, fields stable; ack pulses lsu_resp_valid once.
//  4 mem_resp_valid pulsed in IDLE, then in REQ -> no resp pulses, state unchanged, stray_resp=1 and stays 1 until rst.
//  5 rst asserted in RESP -> next cycle busy=0, no resp pulse; following IFU-vs-LSU tie grants IFU.
//  6 LSU changes lsu_addr to 0x0 during REQ -> mem_addr keeps granted value 0x80002000.

Source files
------------

// File: rtl/ysyx_22040088_mem_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owner encoding and bus widths.
package ysyx_22040088_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 64;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_22040088_mem_arb_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// slave = the arbiter itself, master = the core stages plus memory model around it.
interface ysyx_22040088_mem_arb_if
    import ysyx_22040088_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned MASK_W = MEM_MASK_W
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

endinterface

// File: rtl/ysyx_22040088_rr_arb2.sv
// Combinational two-way round-robin picker; bit 0 = IFU, bit 1 = LSU.
// On a tie the requester that did not win last time is chosen.
module ysyx_22040088_rr_arb2
    import ysyx_22040088_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22040088_mem_arb.sv
// Shares one data-memory port between IFU and LSU, one transaction in flight at a time.
// Request fields are latched at grant; the response is steered back to the owner combinationally.
module ysyx_22040088_mem_arb
    import ysyx_22040088_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned MASK_W = MEM_MASK_W
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22040088_mem_arb_if.slave  bus,
    output logic                    busy,
    output logic                    stray_resp
);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_grant_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              stray_q;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       idle;

    assign req  = {bus.lsu_req_valid, bus.ifu_req_valid};
    assign idle = (state_q == IDLE);

    ysyx_22040088_rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_LSU;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            stray_q         <= 1'b0;
        end else begin
            // A response is only legitimate while waiting for one.
            if (bus.mem_resp_valid && (state_q != RESP)) begin
                stray_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt[1]) begin
                        owner_q         <= OWN_LSU;
                        last_grant_q    <= OWN_LSU;
                        addr_q          <= bus.lsu_addr;
                        wen_q           <= bus.lsu_wen;
                        wdata_q         <= bus.lsu_wdata;
                        wmask_q         <= bus.lsu_wmask;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end else if (gnt[0]) begin
                        owner_q         <= OWN_IFU;
                        last_grant_q    <= OWN_IFU;
                        addr_q          <= bus.ifu_addr;
                        wen_q           <= 1'b0;
                        wdata_q         <= '0;
                        wmask_q         <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready = idle && gnt[0];
    assign bus.lsu_req_ready = idle && gnt[1];

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign bus.ifu_resp_valid = (state_q == RESP) && bus.mem_resp_valid && (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = (state_q == RESP) && bus.mem_resp_valid && (owner_q == OWN_LSU);
    assign bus.ifu_rdata      = bus.mem_rdata;
    assign bus.lsu_rdata      = bus.mem_rdata;

    assign busy       = !idle;
    assign stray_resp = stray_q;

endmodule

// File: tb/tb_ysyx_22040088_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter; expected values are hand-derived per scenario.
module tb_ysyx_22040088_mem_arb;

    logic clk;
    logic rst;
    logic busy;
    logic stray_resp;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22040088_mem_arb_if bus ();

    ysyx_22040088_mem_arb dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .stray_resp (stray_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst_stray", {63'd0, stray_resp}, 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);

        // 1: single IFU fetch at minimum latency
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        bus.mem_req_ready = 1'b1;
        #1;
        check("t1_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd1);
        check("t1_lsu_ready", {63'd0, bus.lsu_req_ready}, 64'd0);
        tick();
        bus.ifu_req_valid = 1'b0;
        #1;
        check("t1_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        check("t1_mem_addr", bus.mem_addr, 64'h8000_0000);
        check("t1_mem_wen", {63'd0, bus.mem_wen}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0010_0073;
        #1;
        check("t1_ifu_resp", {63'd0, bus.ifu_resp_valid}, 64'd1);
        check("t1_ifu_rdata", bus.ifu_rdata, 64'h0010_0073);
        check("t1_lsu_resp", {63'd0, bus.lsu_resp_valid}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t1_idle", {63'd0, busy}, 64'd0);
        check("t1_ifu_resp_done", {63'd0, bus.ifu_resp_valid}, 64'd0);

        // 2: both requesting continuously alternate, IFU first after reset
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h1000;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h2000;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            exp_lsu = (k % 2 == 1);
            #1;
            check($sformatf("t2_ifu_ready%0d", k), {63'd0, bus.ifu_req_ready}, {63'd0, !exp_lsu});
            check($sformatf("t2_lsu_ready%0d", k), {63'd0, bus.lsu_req_ready}, {63'd0, exp_lsu});
            tick();
            #1;
            check($sformatf("t2_mem_addr%0d", k), bus.mem_addr,
                  exp_lsu ? 64'h2000 : 64'h1000);
            tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 64'h55 + 64'(k);
            #1;
            check($sformatf("t2_ifu_resp%0d", k), {63'd0, bus.ifu_resp_valid}, {63'd0, !exp_lsu});
            check($sformatf("t2_lsu_resp%0d", k), {63'd0, bus.lsu_resp_valid}, {63'd0, exp_lsu});
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // 3: LSU store held off by memory for five cycles
        do_reset();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wdata     = 64'hDEAD_BEEF;
        bus.lsu_wmask     = 8'h0F;
        #1;
        check("t3_lsu_ready", {63'd0, bus.lsu_req_ready}, 64'd1);
        tick();
        bus.lsu_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t3_hold_valid%0d", c), {63'd0, bus.mem_req_valid}, 64'd1);
            check($sformatf("t3_hold_addr%0d", c), bus.mem_addr, 64'h8000_1000);
            tick();
        end
        check("t3_wen", {63'd0, bus.mem_wen}, 64'd1);
        check("t3_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
        check("t3_wmask", {56'd0, bus.mem_wmask}, 64'h0F);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t3_req_dropped", {63'd0, bus.mem_req_valid}, 64'd0);
        check("t3_lsu_ack", {63'd0, bus.lsu_resp_valid}, 64'd1);
        check("t3_ifu_no_ack", {63'd0, bus.ifu_resp_valid}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t3_lsu_ack_once", {63'd0, bus.lsu_resp_valid}, 64'd0);
        check("t3_idle", {63'd0, busy}, 64'd0);

        // 4: stray responses in IDLE and REQ are swallowed and flagged
        do_reset();
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t4_idle_ifu_resp", {63'd0, bus.ifu_resp_valid}, 64'd0);
        check("t4_idle_lsu_resp", {63'd0, bus.lsu_resp_valid}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t4_stray_idle", {63'd0, stray_resp}, 64'd1);
        check("t4_still_idle", {63'd0, busy}, 64'd0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0040;
        tick();
        bus.ifu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t4_req_ifu_resp", {63'd0, bus.ifu_resp_valid}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t4_still_req", {63'd0, bus.mem_req_valid}, 64'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t4_real_resp", {63'd0, bus.ifu_resp_valid}, 64'd1);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t4_stray_sticky", {63'd0, stray_resp}, 64'd1);
        do_reset();
        #1;
        check("t4_stray_cleared", {63'd0, stray_resp}, 64'd0);

        // 5: reset while waiting for the response abandons the transaction
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0080;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 64'h3000;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 64'h4000;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t5_busy_after_rst", {63'd0, busy}, 64'd0);
        check("t5_no_ifu_resp", {63'd0, bus.ifu_resp_valid}, 64'd0);
        check("t5_tie_ifu", {63'd0, bus.ifu_req_ready}, 64'd1);
        check("t5_tie_not_lsu", {63'd0, bus.lsu_req_ready}, 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        #1;
        check("t5_late_stray", {63'd0, stray_resp}, 64'd1);
        check("t5_granted_addr", bus.mem_addr, 64'h3000);

        // 6: requester fields changing after grant do not leak to memory
        do_reset();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_2000;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 64'h0;
        #1;
        check("t6_addr_kept0", bus.mem_addr, 64'h8000_2000);
        tick();
        #1;
        check("t6_addr_kept1", bus.mem_addr, 64'h8000_2000);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t6_addr_in_resp", bus.mem_addr, 64'h8000_2000);
        check("t6_lsu_resp", {63'd0, bus.lsu_resp_valid}, 64'd1);
        tick();
        bus.mem_resp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
